id_ex_pipe_reg: RTL

//  Parametrised ID->EX pipeline register for the rv32i core. Captures decoded control,

---
 rtl/id_ex_pipe_reg.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register for the rv32i core.
// Valid tracking, stall/flush, WB bypass, load-use bubble insertion.

package id_ex_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_t;
endpackage

module id_ex_pipe_reg
    import id_ex_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ADW       = 5,
    parameter bit BYPASS_EN = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             validD,
    input  logic             resultsrcD,
    input  logic             memwriteD,
    input  logic             alusrcD,
    input  logic             regwriteD,
    input  alu_op_t          alu_ctrlD,
    input  logic [XLEN-1:0]  rd1D,
    input  logic [XLEN-1:0]  rd2D,
    input  logic [ADW-1:0]   Rs1D,
    input  logic [ADW-1:0]   Rs2D,
    input  logic [ADW-1:0]   RdD,
    input  logic [XLEN-1:0]  immextD,
    input  logic [XLEN-1:0]  pcD,
    input  logic             regwriteW,
    input  logic [ADW-1:0]   RdW,
    input  logic [XLEN-1:0]  resultW,
    input  logic             stallE_in,
    input  logic             flushE_in,
    output logic             validE,
    output logic             resultsrcE,
    output logic             memwriteE,
    output logic             alusrcE,
    output logic             regwriteE,
    output alu_op_t          alu_ctrlE,
    output logic [XLEN-1:0]  srcAE,
    output logic [XLEN-1:0]  rd2E,
    output logic [ADW-1:0]   Rs1E,
    output logic [ADW-1:0]   Rs2E,
    output logic [ADW-1:0]   RdE,
    output logic [XLEN-1:0]  immextE,
    output logic [XLEN-1:0]  pcE,
    output logic             lduse_stall,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic            hit_e1;
    logic            hit_e2;
    logic            byp_a;
    logic            byp_b;
    logic            w_live;
    logic            load_en;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;

    // Hazard detect and WB write-through selection
    always_comb begin
        hit_e1 = (RdE == Rs1D);
        hit_e2 = (RdE == Rs2D);
        lduse_stall = ~stallE_in & validE & resultsrcE & regwriteE
                    & (RdE != '0) & validD & (hit_e1 | hit_e2);
        w_live = BYPASS_EN & regwriteW & (RdW != '0);
        byp_a  = w_live & (RdW == Rs1D);
        byp_b  = w_live & (RdW == Rs2D);
        src_a  = byp_a ? resultW : rd1D;
        src_b  = byp_b ? resultW : rd2D;
        load_en = ~flushE_in & ~stallE_in & ~lduse_stall;
    end

    // Control bits: flush > stall > bubble > load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validE     <= 1'b0;
            resultsrcE <= 1'b0;
            memwriteE  <= 1'b0;
            alusrcE    <= 1'b0;
            regwriteE  <= 1'b0;
        end else if (flushE_in || (!stallE_in && lduse_stall)) begin
            validE     <= 1'b0;
            resultsrcE <= 1'b0;
            memwriteE  <= 1'b0;
            alusrcE    <= 1'b0;
            regwriteE  <= 1'b0;
        end else if (!stallE_in) begin
            validE     <= validD;
            resultsrcE <= validD & resultsrcD;
            memwriteE  <= validD & memwriteD;
            alusrcE    <= validD & alusrcD;
            regwriteE  <= validD & regwriteD & (RdD != '0);
        end
    end

    // Data fields only move on a real load; otherwise they are don't-care and hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_ctrlE <= ALU_ADD;
            srcAE     <= '0;
            rd2E      <= '0;
            Rs1E      <= '0;
            Rs2E      <= '0;
            RdE       <= '0;
            immextE   <= '0;
            pcE       <= '0;
        end else if (load_en) begin
            alu_ctrlE <= alu_ctrlD;
            srcAE     <= src_a;
            rd2E      <= src_b;
            Rs1E      <= Rs1D;
            Rs2E      <= Rs2D;
            RdE       <= RdD;
            immextE   <= immextD;
            pcE       <= pcD;
        end
    end

    // Saturating count of load-use bubbles actually inserted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!flushE_in && lduse_stall && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule
